// File: rtl/dexie_cf_event_buffer.sv
// Control-flow event FIFO between the DExIE trace port and the control-flow checker.
// Optional build macro: DEXIE_CF_FILTER_EN (drop sequential-flow events before buffering).
module dexie_cf_event_buffer #(
  parameter int unsigned DEPTH        = 16,
  parameter int unsigned STALL_MARGIN = 2,
  localparam int unsigned AW          = $clog2(DEPTH),
  localparam int unsigned CW          = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cf_valid,
  input  logic [31:0]   cf_cur_pc,
  input  logic [31:0]   cf_cur_instruction,
  input  logic [31:0]   cf_next_pc,
  output logic          stall,
  output logic          ev_valid,
  input  logic          ev_ready,
  output logic [31:0]   ev_cur_pc,
  output logic [31:0]   ev_instruction,
  output logic [31:0]   ev_next_pc,
  output logic [CW-1:0] count,
  output logic          overflow,
  output logic [15:0]   drop_count
);

  localparam logic [CW-1:0] FullCount  = CW'(DEPTH);
  localparam logic [CW-1:0] StallLevel = CW'(DEPTH - STALL_MARGIN);

  logic [95:0]   mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          stall_q, stall_d;
  logic          overflow_q, overflow_d;
  logic [15:0]   drop_count_q, drop_count_d;

  logic ev_in;
  logic full;
  logic push;
  logic pop;
  logic drop;

`ifdef DEXIE_CF_FILTER_EN
  // Sequential flow carries no checker-relevant information.
  assign ev_in = cf_valid && (cf_next_pc != (cf_cur_pc + 32'd4));
`else
  assign ev_in = cf_valid;
`endif

  assign full = (count_q == FullCount);
  assign pop  = (count_q != '0) && ev_ready;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts.
  assign push = ev_in && (!full || pop);
  assign drop = ev_in && full && !pop;

  always_comb begin
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    count_d      = count_q;
    overflow_d   = overflow_q;
    drop_count_d = drop_count_q;
    if (push) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    count_d = count_q + CW'(push) - CW'(pop);
    if (drop) begin
      overflow_d = 1'b1;
      if (drop_count_q != 16'hFFFF) begin
        drop_count_d = drop_count_q + 16'd1;
      end
    end
    stall_d = (count_d >= StallLevel);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      stall_q      <= 1'b0;
      overflow_q   <= 1'b0;
      drop_count_q <= '0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      stall_q      <= stall_d;
      overflow_q   <= overflow_d;
      drop_count_q <= drop_count_d;
    end
  end

  // Storage is not reset; stale entries are unreachable once pointers are cleared.
  always_ff @(posedge clk) begin
    if (!rst && push) begin
      mem_q[wr_ptr_q] <= {cf_cur_pc, cf_cur_instruction, cf_next_pc};
    end
  end

  assign stall          = stall_q;
  assign ev_valid       = (count_q != '0);
  assign count          = count_q;
  assign overflow       = overflow_q;
  assign drop_count     = drop_count_q;
  assign ev_cur_pc      = mem_q[rd_ptr_q][95:64];
  assign ev_instruction = mem_q[rd_ptr_q][63:32];
  assign ev_next_pc     = mem_q[rd_ptr_q][31:0];

endmodule

// File: doc/dexie_cf_event_buffer.md
# dexie_cf_event_buffer

Downstream buffer between the core's DExIE control-flow trace outputs and the DExIE control-flow checker. Captures each control-flow event (current PC, instruction word, next PC) presented with `cf_valid`, holds it in a FIFO and hands it to the checker over a valid/ready handshake. Raises a registered `stall` back to the core before the FIFO can overflow, so the checker can run slower than the pipeline without losing events.

## Interface
Parameters:
- `DEPTH`, 16: FIFO entries; power of two, >= 4.
- `STALL_MARGIN`, 2: free entries remaining at which `stall` asserts; 1 <= STALL_MARGIN < DEPTH.

Ports:
- `clk`  in  1  core clock; single clock domain.
- `rst`  in  1  synchronous, active-high reset.
- `cf_valid`  in  1  control-flow event present this cycle (already qualified by instruction issue).
- `cf_cur_pc`  in  32  PC of the issuing instruction.
- `cf_cur_instruction`  in  32  instruction word.
- `cf_next_pc`  in  32  resolved successor PC.
- `stall`  out  1  registered back-pressure to the core.
- `ev_valid`  out  1  head entry valid toward the checker.
- `ev_ready`  in  1  checker accepts the head entry.
- `ev_cur_pc`  out  32  head entry current PC.
- `ev_instruction`  out  32  head entry instruction word.
- `ev_next_pc`  out  32  head entry next PC.
- `count`  out  $clog2(DEPTH)+1  current occupancy.
- `overflow`  out  1  sticky: at least one event has been dropped.
- `drop_count`  out  16  saturating count of dropped events.

## Operation
- Storage: DEPTH x 96-bit array; read and write pointers are $clog2(DEPTH) bits wide and wrap naturally at DEPTH; occupancy is tracked in `count`.
- Push: `cf_valid` && (`count` < DEPTH || pop). A push writes {cur_pc, instruction, next_pc} at the write pointer and then increments the pointer.
- Pop: `ev_valid && ev_ready`. A pop increments the read pointer.
- `count` next = count + push - pop. A simultaneous push and pop leaves it unchanged, including when the FIFO is full.
- Drop: `cf_valid` while `count`==DEPTH and no pop in the same cycle. The event is discarded. `overflow` sets and stays set until `rst`. `drop_count` increments and saturates at 16'hFFFF.
- `ev_valid` = (`count` != 0). The `ev_*` data fields show the entry at the read pointer; their value is don't-care when `ev_valid`=0.
- Empty FIFO with simultaneous `cf_valid`: the event is written only and is not bypassed. `ev_valid` rises in the next cycle.
- `stall` next = (count_next >= DEPTH - STALL_MARGIN).
- Reset mid-operation: all entries are abandoned, pointers return to 0, and all outputs go to their reset values. An event presented in the reset cycle is not captured.

## Timing
- Reset values: `stall`=0, `ev_valid`=0, `count`=0, `overflow`=0, `drop_count`=0.
- Push-to-output latency: an event pushed in cycle N gives `ev_valid`=1 with its data in cycle N+1.
- Handshake: the head entry is held stable while `ev_valid && !ev_ready`. `ev_valid` never drops without a pop.
- `stall` is driven from a register (cycle N state -> visible in cycle N+1). The core needs one cycle to react, so STALL_MARGIN >= 1 guarantees no drop if the core honours `stall` within one cycle.
- Throughput: one push and one pop per cycle sustained.

## Configuration
- Macro: `DEXIE_CF_FILTER_EN`.
- Defined: events with `cf_next_pc` == `cf_cur_pc` + 32'd4 (sequential flow) are discarded before the push logic. Such events are not stored, are not counted in `count`, and are not counted as drops. Only discontinuities (taken branches, jumps, traps, returns) are buffered.
- Undefined: every `cf_valid` event is pushed as described in Operation. This is the default build.

## Test plan
- Single event: after reset, one-cycle `cf_valid` with cur_pc=0x100, instr=0x00C0006F, next_pc=0x10C, and `ev_ready`=0 -> cycle+1: `ev_valid`=1 with those three values, `count`=1. Assert `ev_ready` -> following cycle: `ev_valid`=0, `count`=0.
- Fill and stall (DEPTH=16, STALL_MARGIN=2): push 14 events with `ev_ready`=0 -> `stall`=1 in the cycle after the 14th push. Push 2 more -> `count`=16, `overflow`=0.
- Overflow: with `count`=16 and `ev_ready`=0, assert `cf_valid` for 3 cycles -> `overflow`=1, `drop_count`=3. Then drain: 16 entries come out in push order, and none of the dropped events appear.
- Full with simultaneous push/pop: `count`=16, `cf_valid`=1, `ev_ready`=1 -> `count` stays 16, no drop, and the new entry appears after the existing 16.
- Pointer wrap: stream 40 events while holding `ev_ready`=1 -> `count` never exceeds 1 and the output sequence equals the input sequence. Then reset mid-stream -> next cycle `count`=0, `ev_valid`=0, `stall`=0.
- Filter build (`DEXIE_CF_FILTER_EN`): push (0x200 -> 0x204), then (0x204 -> 0x300) -> only the 0x204->0x300 event is buffered, `count`=1, `drop_count`=0.
